pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Registered program-counter unit for the pipelined core; replaces the purely combinational next-PC adder.
//  Holds the architectural PC and computes next_pc from sequential / PC-relative / register-relative sources.
//  Supports stall hold and trap redirect, plus a DEPTH-entry return-address stack (RAS) for call/return.
//  Sits at the head of IF; pc drives the instruction memory address.
// PARAMETERS
//  XLEN        32            datapath width of pc, Ra, imm, trap_vec
//  RESET_VEC   32'h0000_0000 value loaded into pc on reset
//  INST_BYTES  4             sequential increment (4 = RV32I; 2 = compressed support)
//  DEPTH       4             RAS entries (power of two, >= 2)
// PORTS
//  clk        in   1     rising-edge clock
//  rst        in   1     synchronous, active-high reset
//  stall      in   1     1: hold pc and RAS this cycle
//  PCAsrc     in   1     offset select: 1 = imm, 0 = INST_BYTES
//  PCBsrc     in   1     base select: 1 = Ra (JALR), 0 = pc
//  Ra         in   XLEN  register base operand
//  imm        in   XLEN  sign-extended immediate offset
//  trap       in   1     redirect to trap_vec, overrides stall and RAS
//  trap_vec   in   XLEN  trap handler address
//  ras_push   in   1     call: push pc+INST_BYTES
//  ras_pop    in   1     return: take RAS top as next_pc
//  pc         out  XLEN  current PC (registered)
//  next_pc    out  XLEN  selected next PC (combinational)
//  ras_top    out  XLEN  top RAS entry; 0 when empty
//  ras_empty  out  1     RAS holds no entries
//  ras_full   out  1     RAS holds DEPTH entries
//  misalign   out  1     next_pc not INST_BYTES-aligned (combinational)
// BEHAVIOUR
//  - Reset (rst=1 at edge): pc<=RESET_VEC, RAS count<=0, ptr<=0; ras_empty=1, ras_full=0, ras_top=0.
//  - Target: tgt = (PCBsrc ? Ra : pc) + (PCAsrc ? imm : INST_BYTES), modulo 2^XLEN (wrap, no carry out).
//    When PCBsrc=1, tgt[0] forced to 0 (JALR rule).
//  - next_pc priority: trap -> trap_vec; else ras_pop & !ras_empty -> ras_top; else tgt.
//  - pc update at edge: trap=1 -> pc<=trap_vec regardless of stall; else stall=1 -> hold; else pc<=next_pc.
//    Latency: next_pc visible on pc one cycle later.
//  - RAS acts only when stall=0 and trap=0:
//    push only: write pc+INST_BYTES at top, count+1; if full, overwrite oldest (circular wrap), count stays DEPTH.
//    pop only: if !empty, count-1; pop on empty is ignored, next_pc falls back to tgt.
//    push & pop together: top entry replaced by pc+INST_BYTES, count unchanged; next_pc = old ras_top.
//  - trap=1 at edge flushes RAS (count<=0), regardless of push/pop.
//  - rst overrides trap, stall and all RAS ops.
//  - misalign = |next_pc[log2(INST_BYTES)-1:0]; advisory only, pc still loads next_pc.
// TESTING
//  1. rst 2 cycles, release, no controls -> pc 0,4,8,12 on successive cycles; ras_empty=1.
//  2. pc=0x100, PCAsrc=1, imm=-8 -> next_pc=0xF8, pc=0xF8 next cycle; stall=1 then holds 0xF8.
//  3. PCBsrc=1, PCAsrc=1, Ra=0x2001, imm=4 -> next_pc=0x2004 (bit0 cleared); pc=0xFFFF_FFFC seq -> 0.
//  4. DEPTH=4: push at pc=0x10,0x20,0x30,0x40,0x50 -> full, pops return 0x54,0x44,0x34,0x24 then empty;
//     pop on empty -> next_pc=tgt.
//  5. push with stall=1 and trap=1 together, trap_vec=0x800 -> pc=0x800, RAS empty, no push.
//  6. Simultaneous push & pop at pc=0x60, top=0x24 -> next_pc=0x24, new top=0x64, count unchanged.

Source files
------------

// File: rtl/pc_unit.sv
// Registered program counter with stall hold, trap redirect and a circular
// return-address stack. next_pc and misalign are combinational from current state.
module pc_unit #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_VEC  = '0,
   parameter int              INST_BYTES = 4,
   parameter int              DEPTH      = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            PCAsrc,
   input  logic            PCBsrc,
   input  logic [XLEN-1:0] Ra,
   input  logic [XLEN-1:0] imm,
   input  logic            trap,
   input  logic [XLEN-1:0] trap_vec,
   input  logic            ras_push,
   input  logic            ras_pop,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] next_pc,
   output logic [XLEN-1:0] ras_top,
   output logic            ras_empty,
   output logic            ras_full,
   output logic            misalign
);

   localparam int              PW       = $clog2(DEPTH);
   localparam int              AW       = $clog2(INST_BYTES);
   localparam logic [XLEN-1:0] INC      = XLEN'(INST_BYTES);
   localparam logic [PW:0]     FULL_CNT = (PW+1)'(DEPTH);
   localparam logic [PW:0]     CNT_ONE  = (PW+1)'(1);
   localparam logic [PW-1:0]   PTR_ONE  = PW'(1);

   logic [XLEN-1:0] ras_mem [DEPTH];
   logic [PW-1:0]   ptr_reg;
   logic [PW:0]     count_reg;
   logic [XLEN-1:0] pc_reg;

   logic [PW-1:0]   top_idx;
   logic [XLEN-1:0] base;
   logic [XLEN-1:0] offset;
   logic [XLEN-1:0] tgt;
   logic [XLEN-1:0] ret_addr;
   logic            ras_act;
   logic            pop_ok;
   logic            wr_en;
   logic [PW-1:0]   wr_addr;

   assign pc        = pc_reg;
   assign top_idx   = ptr_reg - PTR_ONE;
   assign ras_empty = (count_reg == '0);
   assign ras_full  = (count_reg == FULL_CNT);
   assign ras_top   = ras_empty ? '0 : ras_mem[top_idx];
   assign ret_addr  = pc_reg + INC;
   assign ras_act   = !trap && !stall;
   assign pop_ok    = ras_pop && !ras_empty;

   always_comb begin
      base   = PCBsrc ? Ra : pc_reg;
      offset = PCAsrc ? imm : INC;
      tgt    = base + offset;
      if (PCBsrc)
         tgt[0] = 1'b0;
      if (trap)
         next_pc = trap_vec;
      else if (pop_ok)
         next_pc = ras_top;
      else
         next_pc = tgt;
   end

   generate
      if (AW > 0) begin : g_misalign
         assign misalign = |next_pc[AW-1:0];
      end else begin : g_no_misalign
         assign misalign = 1'b0;
      end
   endgenerate

   // A combined push+pop rewrites the current top in place; otherwise pushes land at ptr.
   assign wr_en   = !rst && ras_act && ras_push;
   assign wr_addr = pop_ok ? top_idx : ptr_reg;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_ras
         always_ff @(posedge clk) begin
            if (wr_en && (wr_addr == PW'(gi)))
               ras_mem[gi] <= ret_addr;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg    <= RESET_VEC;
         count_reg <= '0;
         ptr_reg   <= '0;
      end else if (trap) begin
         pc_reg    <= trap_vec;
         count_reg <= '0;
         ptr_reg   <= '0;
      end else if (!stall) begin
         pc_reg <= next_pc;
         if (ras_push && !pop_ok) begin
            // Full stack wraps onto the oldest entry; count saturates.
            ptr_reg <= ptr_reg + PTR_ONE;
            if (!ras_full)
               count_reg <= count_reg + CNT_ONE;
         end else if (!ras_push && pop_ok) begin
            ptr_reg   <= top_idx;
            count_reg <= count_reg - CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboarded random/directed bench for pc_unit against a queue-based PC/RAS model.
module tb_pc_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, stall, PCAsrc, PCBsrc, trap, ras_push, ras_pop;
   logic [31:0] Ra, imm, trap_vec;
   logic [31:0] pc, next_pc, ras_top;
   logic        ras_empty, ras_full, misalign;

   pc_unit #(.XLEN(32), .RESET_VEC(32'h0), .INST_BYTES(4), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .stall(stall), .PCAsrc(PCAsrc), .PCBsrc(PCBsrc),
      .Ra(Ra), .imm(imm), .trap(trap), .trap_vec(trap_vec),
      .ras_push(ras_push), .ras_pop(ras_pop), .pc(pc), .next_pc(next_pc),
      .ras_top(ras_top), .ras_empty(ras_empty), .ras_full(ras_full), .misalign(misalign)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] npc;
      logic [31:0] top;
      logic        empty;
      logic        full;
      logic        mis;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] m_pc;
   logic [31:0] m_stack[$];
   int          vectors = 0;
   int          miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: the DUT presents outputs every cycle once stimulus is applied.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         vectors++;
         chk("pc", pc, e.pc);
         chk("next_pc", next_pc, e.npc);
         chk("ras_top", ras_top, e.top);
         chk("ras_empty", {31'b0, ras_empty}, {31'b0, e.empty});
         chk("ras_full", {31'b0, ras_full}, {31'b0, e.full});
         chk("misalign", {31'b0, misalign}, {31'b0, e.mis});
         $display("vec %0d pc=%h next_pc=%h ras_top=%h empty=%0b full=%0b mis=%0b",
                  vectors, pc, next_pc, ras_top, ras_empty, ras_full, misalign);
      end
   end

   task automatic step(input logic r, input logic st, input logic pa, input logic pb,
                       input logic tr, input logic pu, input logic po,
                       input logic [31:0] ra_v, input logic [31:0] im_v, input logic [31:0] tv_v);
      exp_t        e;
      logic [31:0] tgt;
      logic [31:0] top;
      logic [31:0] npc;
      int          n;
      rst = r; stall = st; PCAsrc = pa; PCBsrc = pb; trap = tr;
      ras_push = pu; ras_pop = po; Ra = ra_v; imm = im_v; trap_vec = tv_v;

      n   = m_stack.size();
      tgt = (pb ? ra_v : m_pc) + (pa ? im_v : 32'd4);
      if (pb) tgt = tgt & ~32'd1;
      top = (n > 0) ? m_stack[n-1] : 32'd0;
      if (tr)                npc = tv_v;
      else if (po && n > 0)  npc = top;
      else                   npc = tgt;
      e.pc = m_pc; e.npc = npc; e.top = top;
      e.empty = (n == 0); e.full = (n == DEPTH); e.mis = (npc[1:0] != 2'b00);
      sb_q.push_back(e);

      if (r) begin
         m_pc = 32'h0; m_stack.delete();
      end else if (tr) begin
         m_pc = tv_v; m_stack.delete();
      end else if (!st) begin
         if (pu && po && n > 0) begin
            m_stack[n-1] = m_pc + 32'd4;
         end else if (pu) begin
            m_stack.push_back(m_pc + 32'd4);
            if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
         end else if (po && n > 0) begin
            void'(m_stack.pop_back());
         end
         m_pc = npc;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic nop();
      step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; PCAsrc = 1'b0; PCBsrc = 1'b0; trap = 1'b0;
      ras_push = 1'b0; ras_pop = 1'b0; Ra = '0; imm = '0; trap_vec = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      m_pc = 32'h0;
      m_stack.delete();

      // Sequential fetch from reset
      repeat (5) nop();

      // Backward branch then stall hold
      step(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h100);
      step(0, 0, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFF8, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0, 0, 0, 32'h40, 0);

      // JALR bit-0 clear and address wrap
      step(0, 0, 1, 1, 0, 0, 0, 32'h2001, 32'h4, 0);
      step(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC);
      nop();
      nop();

      // Fill and overflow the RAS, drain it, then pop on empty
      step(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h10);
      repeat (5) step(0, 0, 1, 0, 0, 1, 0, 0, 32'h10, 0);
      repeat (5) step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      nop();

      // Simultaneous push and pop replaces top
      step(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h20);
      step(0, 0, 1, 0, 0, 1, 0, 0, 32'h40, 0);
      step(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      nop();

      // Trap beats stall and push
      step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 1, 1, 0, 0, 0, 32'h800);
      nop();

      // Misaligned target is advisory; pc still loads it
      step(0, 0, 1, 0, 0, 0, 0, 0, 32'h2, 0);
      nop();

      for (int i = 0; i < 2000; i++) begin
         logic        r, st, tr, pu, po, pa, pb;
         logic [31:0] ra_v, im_v, tv_v;
         r    = ($urandom_range(0, 255) == 0);
         st   = ($urandom_range(0, 7) == 0);
         tr   = ($urandom_range(0, 31) == 0);
         pu   = ($urandom_range(0, 3) == 0);
         po   = ($urandom_range(0, 3) == 0);
         pa   = $urandom_range(0, 1);
         pb   = ($urandom_range(0, 3) == 0);
         ra_v = $urandom;
         im_v = ($urandom_range(0, 7) == 0) ? $urandom : (($urandom_range(0, 255) - 128) << 2);
         tv_v = $urandom & 32'hFFFF_FFFC;
         if (pu && po && m_stack.size() == 0) po = 1'b0;
         step(r, st, pa, pb, tr, pu, po, ra_v, im_v, tv_v);
      end

      repeat (3) @(negedge clk);
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
